// File: rtl/fwd_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: shadows the EX, MEM and WB destinations,
// selects ALU operand forwarding sources and detects load-use stalls.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_regwrite_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic             vld_p0, rw_p0, mr_p0;
  logic [REG_W-1:0] rs_p0, rt_p0, dst_p0;
  logic             vld_p1, rw_p1;
  logic [REG_W-1:0] dst_p1;
  logic             vld_p2, rw_p2;
  logic [REG_W-1:0] dst_p2;
  logic             hazard;
  logic             bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The newest producer (EX/MEM) wins over MEM/WB; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (vld_p1 && rw_p1 && (dst_p1 != '0) && (dst_p1 == src))
      return 2'd2;
    else if (vld_p2 && rw_p2 && (dst_p2 != '0) && (dst_p2 == src))
      return 2'd1;
    else
      return 2'd0;
  endfunction

  always_comb begin
    hazard = id_valid_i & vld_p0 & mr_p0 & rw_p0 & (dst_p0 != '0) &
             ((dst_p0 == id_rs_i) | (id_uses_rt_i & (dst_p0 == id_rt_i)));
  end

  assign stall_o     = hazard & ~flush_i;
  assign bubble      = stall_o | flush_i;
  assign forward_a_o = fwd_sel(rs_p0);
  assign forward_b_o = fwd_sel(rt_p0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p0      <= 1'b0;
      rw_p0       <= 1'b0;
      mr_p0       <= 1'b0;
      rs_p0       <= '0;
      rt_p0       <= '0;
      dst_p0      <= '0;
      vld_p1      <= 1'b0;
      rw_p1       <= 1'b0;
      dst_p1      <= '0;
      vld_p2      <= 1'b0;
      rw_p2       <= 1'b0;
      dst_p2      <= '0;
      stall_cnt_o <= '0;
    end else begin
      // MEM/WB <= EX/MEM <= ID/EX
      vld_p2 <= vld_p1;
      rw_p2  <= rw_p1;
      dst_p2 <= dst_p1;
      vld_p1 <= vld_p0;
      rw_p1  <= rw_p0;
      dst_p1 <= dst_p0;
      // ID/EX takes a bubble on a stall or a flush
      if (bubble) begin
        vld_p0 <= 1'b0;
        rw_p0  <= 1'b0;
        mr_p0  <= 1'b0;
        rs_p0  <= '0;
        rt_p0  <= '0;
        dst_p0 <= '0;
      end else begin
        vld_p0 <= id_valid_i;
        rw_p0  <= id_regwrite_i;
        mr_p0  <= id_memread_i;
        rs_p0  <= id_rs_i;
        rt_p0  <= id_rt_i;
        dst_p0 <= id_dst_i;
      end
      if (stall_o)
        stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a driver queues hand-computed expectations per
// cycle, a negedge monitor pops and compares. A CNT_W=2 copy exercises counter saturation.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs_i = '0;
  logic [4:0] id_rt_i = '0;
  logic       id_uses_rt_i = 1'b0;
  logic       id_regwrite_i = 1'b0;
  logic [4:0] id_dst_i = '0;
  logic       id_memread_i = 1'b0;
  logic       flush_i = 1'b0;

  logic        stall_o, stall2;
  logic [1:0]  fa_o, fb_o, fa2, fb2;
  logic [15:0] cnt_o;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       st;
    logic [1:0] fa;
    logic [1:0] fb;
    int         c16;
    int         c2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
    .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i), .id_regwrite_i(id_regwrite_i),
    .id_dst_i(id_dst_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
    .stall_o(stall_o), .forward_a_o(fa_o), .forward_b_o(fb_o), .stall_cnt_o(cnt_o)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
    .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i), .id_regwrite_i(id_regwrite_i),
    .id_dst_i(id_dst_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
    .stall_o(stall2), .forward_a_o(fa2), .forward_b_o(fb2), .stall_cnt_o(cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one ID-stage cycle and queue what the outputs must be during it.
  task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ur, input logic rw, input logic [4:0] dst, input logic mr,
                     input logic fl, input logic es, input logic [1:0] ea, input logic [1:0] eb,
                     input int c16, input int c2);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = ur;
    id_regwrite_i = rw; id_dst_i = dst; id_memread_i = mr; flush_i = fl;
    e.tag = tag; e.st = es; e.fa = ea; e.fb = eb; e.c16 = c16; e.c2 = c2;
    q.push_back(e);
  endtask

  task automatic nop(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                     input int c16, input int c2);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, c16, c2);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".stall"}, int'(stall_o), int'(e.st));
      chk({e.tag, ".fwd_a"}, int'(fa_o), int'(e.fa));
      chk({e.tag, ".fwd_b"}, int'(fb_o), int'(e.fb));
      chk({e.tag, ".cnt"},   int'(cnt_o), e.c16);
      chk({e.tag, ".cnt2"},  int'(cnt2), e.c2);
      chk({e.tag, ".stall2"}, int'(stall2), int'(e.st));
      chk({e.tag, ".fwd_a2"}, int'(fa2), int'(e.fa));
    end
  end

  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    // Reset held with random ID inputs
    for (int i = 0; i < 3; i++)
      cyc("rst_hold", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_i = 1'b1;

    // EX/MEM forward on both operands
    cyc("exmem_c1", 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc("exmem_c2", 1, 3, 3, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    nop("exmem_use", 2, 2, 0, 0);
    // MEM/WB forward
    cyc("memwb_c1", 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc("memwb_c2", 1, 1, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc("memwb_c3", 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("memwb_use", 1, 0, 0, 0);
    // Both stages match: newest wins
    cyc("prio_c1", 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc("prio_c2", 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc("prio_c3", 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop("prio_use", 2, 0, 0, 0);
    // Load-use: one stall cycle, bubble, then MEM/WB forward
    cyc("lu_load",  1, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
    cyc("lu_stall", 1, 4, 2, 1, 1, 8, 0, 0, 1, 0, 0, 0, 0);
    cyc("lu_hold",  1, 4, 2, 1, 1, 8, 0, 0, 0, 0, 0, 1, 1);
    nop("lu_use", 1, 0, 1, 1);
    // Zero register never stalls or forwards
    cyc("r0_load", 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
    cyc("r0_use",  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop("r0_ex", 0, 0, 1, 1);
    // Flush beats the load-use hazard
    cyc("fl_load", 1, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1, 1);
    cyc("fl_kill", 1, 4, 0, 0, 1, 9, 0, 1, 0, 0, 0, 1, 1);
    nop("fl_ex", 0, 0, 1, 1);
    nop("fl_after", 0, 0, 1, 1);
    // Four more load-use pairs drive the 2-bit counter into saturation
    for (int k = 0; k < 4; k++) begin
      cyc("sat_load",  1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1 + k, sat2(1 + k));
      cyc("sat_stall", 1, 4, 2, 1, 1, 8, 0, 0, 1, 0, 0, 1 + k, sat2(1 + k));
      cyc("sat_hold",  1, 4, 2, 1, 1, 8, 0, 0, 0, 0, 0, 2 + k, sat2(2 + k));
      nop("sat_use", 1, 0, 2 + k, sat2(2 + k));
    end
    // Stall plus EX/MEM forwarding, then asynchronous reset between edges
    cyc("ar_c1", 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 5, 3);
    cyc("ar_c2", 1, 3, 3, 0, 1, 4, 1, 0, 0, 0, 0, 5, 3);
    cyc("ar_c3", 1, 4, 0, 0, 1, 8, 0, 0, 1, 2, 2, 5, 3);
    @(negedge clk);
    #1 rst_i = 1'b0;
    #1;
    chk("async_rst.stall", int'(stall_o), 0);
    chk("async_rst.fwd_a", int'(fa_o), 0);
    chk("async_rst.fwd_b", int'(fb_o), 0);
    chk("async_rst.cnt",   int'(cnt_o), 0);
    chk("async_rst.cnt2",  int'(cnt2), 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Tracks destination-register state of the instructions in ID/EX, EX/MEM and MEM/WB in internal shadow registers.
- Drives the 2-bit select inputs of the two 3-to-1 ALU-operand forwarding muxes, and raises a load-use stall that holds PC and IF/ID.
- Counts stall cycles for performance measurement.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall-counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- id_valid_i  input  1  ID stage holds a real instruction.
- id_rs_i  input  REG_W  rs specifier of the ID instruction.
- id_rt_i  input  REG_W  rt specifier of the ID instruction.
- id_uses_rt_i  input  1  ID instruction reads rt as a source.
- id_regwrite_i  input  1  ID instruction writes the register file.
- id_dst_i  input  REG_W  destination register of the ID instruction (already rd/rt-selected).
- id_memread_i  input  1  ID instruction is a load.
- flush_i  input  1  kill the ID instruction (taken branch/jump).
- stall_o  output  1  hold PC and IF/ID; bubble into ID/EX.
- forward_a_o  output  2  select for the operand-A forwarding mux.
- forward_b_o  output  2  select for the operand-B forwarding mux.
- stall_cnt_o  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Shadow state, all cleared by reset:
  - ex_*: valid, rs, rt, dst, regwrite, memread.
  - mem_*: valid, dst, regwrite.
  - wb_*: valid, dst, regwrite.
- Reset (rst_i=0), asynchronous: all valid bits, fields and stall_cnt_o go to 0 immediately. stall_o=0 and forward_a_o=forward_b_o=0 while reset is held. Reset asserted mid-stall clears the stall in the same cycle.
- Each rising edge (rst_i=1):
  - wb <= mem; mem <= ex.
  - ex <= bubble (valid=0, regwrite=0, memread=0, fields 0) if stall_o or flush_i; otherwise ex <= ID inputs.
  - An ID input with id_valid_i=0 loads with valid=0.
- Hazard term (combinational): id_valid_i & ex_valid & ex_memread & ex_regwrite & ex_dst!=0 & (ex_dst==id_rs_i | (id_uses_rt_i & ex_dst==id_rt_i)).
- stall_o = hazard & ~flush_i. Flush has priority: the killed instruction never stalls.
- A stall lasts exactly one cycle per load-use pair. Next cycle the load sits in EX/MEM with a bubble in ID/EX, so the hazard term is 0.
- Forward select encoding (mux data index):
  - 0 = ID/EX register-file value.
  - 1 = MEM/WB writeback data.
  - 2 = EX/MEM ALU result.
- forward_a_o (combinational from shadow regs, same cycle the consumer is in EX):
  - 2 if mem_valid & mem_regwrite & mem_dst!=0 & mem_dst==ex_rs.
  - else 1 if wb_valid & wb_regwrite & wb_dst!=0 & wb_dst==ex_rs.
  - else 0.
- forward_b_o: identical, using ex_rt.
- EX/MEM match beats MEM/WB match when both hit (newest value wins).
- Register 0 is never forwarded and never causes a stall.
- Select value 3 is never produced.
- stall_cnt_o: increments on each rising edge where stall_o=1. It saturates at 2^CNT_W-1 and does not wrap. It is cleared only by reset.
- No output depends combinationally on clk_i. stall_o depends combinationally on the ID inputs and flush_i. Forward selects depend only on state.

Test Plan:
- Reset: hold rst_i=0 with random ID inputs for 3 cycles -> stall_o=0, forward_a_o=forward_b_o=0, stall_cnt_o=0. Repeat with rst_i asserted between edges -> outputs clear without a clock edge.
- EX/MEM forward: issue add $3 (regwrite, dst=3), then sub rs=3, rt=3 (uses_rt) -> in the cycle sub is in EX, forward_a_o=2 and forward_b_o=2, stall_o never 1.
- MEM/WB forward and priority:
  - Issue dst=5, then an unrelated instruction, then rs=5 -> forward_a_o=1.
  - Issue dst=5, dst=5, then rs=5 -> forward_a_o=2.
- Load-use: issue lw dst=4 (memread), then add rs=4 -> stall_o=1 for exactly one cycle, ex bubble inserted, stall_cnt_o goes 0->1. Next cycle add is in EX -> forward_a_o=1.
- Zero register and flush:
  - lw dst=0 followed by rs=0 -> no stall, forward 0.
  - lw dst=4 followed by rs=4 with flush_i=1 -> stall_o=0; killed instruction yields forward 0 and no counter increment.
- Counter saturation: CNT_W=2, create 5 load-use stalls -> stall_cnt_o reads 1,2,3,3,3.
